// File: rtl/bp_sacc_io_initiator.sv
// Host-side initiator for the streaming-accelerator I/O path: turns one client register
// read/write into one uncached BedRock mem command and waits for its matching response.
package bp_sacc_io_pkg;
  typedef enum {e_bp_default_cfg} bp_params_e;

  localparam int paddr_width_p  = 40;
  localparam int lce_id_width_p = 8;
  localparam int did_width_p    = 3;
  localparam int lce_assoc_p    = 8;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1  = 3'd0,
    e_bedrock_msg_size_2  = 3'd1,
    e_bedrock_msg_size_4  = 3'd2,
    e_bedrock_msg_size_8  = 3'd3,
    e_bedrock_msg_size_16 = 3'd4,
    e_bedrock_msg_size_32 = 3'd5,
    e_bedrock_msg_size_64 = 3'd6
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic                             speculative;
    logic                             uncached;
    logic                             prefetch;
    logic [2:0]                       state;
    logic [$clog2(lce_assoc_p)-1:0]   way_id;
    logic [did_width_p-1:0]           did;
    logic [lce_id_width_p-1:0]        lce_id;
  } bp_bedrock_mem_payload_s;

  typedef struct packed {
    bp_bedrock_mem_payload_s          payload;
    bp_bedrock_msg_size_e             size;
    logic [paddr_width_p-1:0]         addr;
    logic [3:0]                       subop;
    bp_bedrock_mem_type_e             msg_type;
  } bp_bedrock_mem_header_s;
endpackage

module bp_sacc_io_initiator
  import bp_sacc_io_pkg::*;
#(
  parameter bp_params_e bp_params_p  = e_bp_default_cfg,
  parameter int         data_width_p = 64,
  parameter int         timeout_p    = 1024,
  localparam int        hdr_w        = $bits(bp_bedrock_mem_header_s)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [lce_id_width_p-1:0] lce_id_i,

  input  logic                      req_v_i,
  output logic                      req_ready_and_o,
  input  logic                      req_we_i,
  input  logic [paddr_width_p-1:0]  req_addr_i,
  input  logic [data_width_p-1:0]   req_data_i,

  output logic                      resp_v_o,
  input  logic                      resp_yumi_i,
  output logic [data_width_p-1:0]   resp_data_o,
  output logic                      resp_err_o,

  output logic [hdr_w-1:0]          io_cmd_header_o,
  output logic [data_width_p-1:0]   io_cmd_data_o,
  output logic                      io_cmd_v_o,
  input  logic                      io_cmd_ready_and_i,

  input  logic [hdr_w-1:0]          io_resp_header_i,
  input  logic [data_width_p-1:0]   io_resp_data_i,
  input  logic                      io_resp_v_i,
  output logic                      io_resp_yumi_o,

  output logic [7:0]                stray_count_o
);

  localparam int  cnt_w      = ($clog2(timeout_p) > 0) ? $clog2(timeout_p) : 1;
  localparam bit  unused_cfg = (bp_params_p == e_bp_default_cfg);

  typedef enum logic [1:0] {e_idle, e_send, e_wait, e_done} state_e;

  state_e                    state_q, state_d;
  logic [cnt_w-1:0]          cnt_q, cnt_d;
  logic                      we_q, we_d;
  bp_bedrock_mem_header_s    hdr_q, hdr_d, hdr_new;
  logic [data_width_p-1:0]   cmd_data_q, cmd_data_d;
  logic [data_width_p-1:0]   resp_data_q, resp_data_d;
  logic                      resp_err_q, resp_err_d;
  logic [7:0]                stray_q, stray_d;

  bp_bedrock_mem_header_s    resp_hdr;
  logic                      resp_match;
  logic                      unused_resp_bits;

  assign resp_hdr         = io_resp_header_i;
  assign resp_match       = (resp_hdr.msg_type == hdr_q.msg_type) && (resp_hdr.addr == hdr_q.addr);
  assign unused_resp_bits = ^{resp_hdr.payload, resp_hdr.size, resp_hdr.subop};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= e_idle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      hdr_q       <= '0;
      cmd_data_q  <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      stray_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      hdr_q       <= hdr_d;
      cmd_data_q  <= cmd_data_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      stray_q     <= stray_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    we_d           = we_q;
    hdr_d          = hdr_q;
    cmd_data_d     = cmd_data_q;
    resp_data_d    = resp_data_q;
    resp_err_d     = resp_err_q;
    stray_d        = stray_q;
    io_resp_yumi_o = 1'b0;

    hdr_new                = '0;
    hdr_new.msg_type       = req_we_i ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
    hdr_new.addr           = req_addr_i;
    hdr_new.size           = e_bedrock_msg_size_8;
    hdr_new.payload.lce_id = lce_id_i;

    // Anything arriving before the command is on the wire cannot be ours
    if ((state_q == e_idle) || (state_q == e_send)) begin
      io_resp_yumi_o = io_resp_v_i;
      if (io_resp_v_i && (stray_q != 8'hFF))
        stray_d = stray_q + 8'd1;
    end

    case (state_q)
      e_idle: begin
        if (req_v_i) begin
          we_d       = req_we_i;
          hdr_d      = hdr_new;
          cmd_data_d = req_we_i ? req_data_i : '0;
          if (req_addr_i[2:0] != 3'b000) begin
            state_d     = e_done;
            resp_err_d  = 1'b1;
            resp_data_d = '0;
          end else begin
            state_d = e_send;
          end
        end
      end
      e_send: begin
        if (io_cmd_ready_and_i) begin
          state_d = e_wait;
          cnt_d   = '0;
        end
      end
      e_wait: begin
        cnt_d = cnt_q + 1'b1;
        if (io_resp_v_i) begin
          io_resp_yumi_o = 1'b1;
          state_d        = e_done;
          if (!resp_match) begin
            resp_err_d  = 1'b1;
            resp_data_d = '0;
          end else begin
            resp_err_d  = 1'b0;
            resp_data_d = we_q ? '0 : io_resp_data_i;
          end
        end else if (cnt_q == cnt_w'(timeout_p - 1)) begin
          state_d     = e_done;
          resp_err_d  = 1'b1;
          resp_data_d = '0;
        end
      end
      e_done: begin
        if (resp_yumi_i)
          state_d = e_idle;
      end
      default: state_d = e_idle;
    endcase
  end

  assign req_ready_and_o = (state_q == e_idle);
  assign io_cmd_v_o      = (state_q == e_send);
  assign resp_v_o        = (state_q == e_done);
  assign io_cmd_header_o = hdr_q;
  assign io_cmd_data_o   = cmd_data_q;
  assign resp_data_o     = resp_data_q;
  assign resp_err_o      = resp_err_q;
  assign stray_count_o   = stray_q;

endmodule

// File: tb/tb_bp_sacc_io_initiator.sv
// Directed bench for bp_sacc_io_initiator: hand-computed expectations for writes, reads,
// timeout, misalignment, mismatched and stray responses, backpressure and async reset.
module tb_bp_sacc_io_initiator;
  import bp_sacc_io_pkg::*;

  localparam int DW    = 64;
  localparam int TO    = 16;
  localparam int HDR_W = $bits(bp_bedrock_mem_header_s);

  logic                      clk;
  logic                      reset_n;
  logic [lce_id_width_p-1:0] lce_id;
  logic                      req_v, req_ready, req_we;
  logic [paddr_width_p-1:0]  req_addr;
  logic [DW-1:0]             req_data;
  logic                      resp_v, resp_yumi, resp_err;
  logic [DW-1:0]             resp_data;
  logic [HDR_W-1:0]          cmd_hdr_raw;
  logic [DW-1:0]             cmd_data;
  logic                      cmd_v, cmd_ready;
  bp_bedrock_mem_header_s    rsp_hdr;
  logic [DW-1:0]             rsp_data;
  logic                      rsp_v, rsp_yumi;
  logic [7:0]                stray;
  bp_bedrock_mem_header_s    ch;

  int n_chk = 0;
  int n_err = 0;

  assign ch = cmd_hdr_raw;

  bp_sacc_io_initiator #(.data_width_p(DW), .timeout_p(TO)) dut (
    .clk_i              (clk),
    .reset_n_i          (reset_n),
    .lce_id_i           (lce_id),
    .req_v_i            (req_v),
    .req_ready_and_o    (req_ready),
    .req_we_i           (req_we),
    .req_addr_i         (req_addr),
    .req_data_i         (req_data),
    .resp_v_o           (resp_v),
    .resp_yumi_i        (resp_yumi),
    .resp_data_o        (resp_data),
    .resp_err_o         (resp_err),
    .io_cmd_header_o    (cmd_hdr_raw),
    .io_cmd_data_o      (cmd_data),
    .io_cmd_v_o         (cmd_v),
    .io_cmd_ready_and_i (cmd_ready),
    .io_resp_header_i   (rsp_hdr),
    .io_resp_data_i     (rsp_data),
    .io_resp_v_i        (rsp_v),
    .io_resp_yumi_o     (rsp_yumi),
    .stray_count_o      (stray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bp_bedrock_mem_header_s mk_hdr(input bp_bedrock_mem_type_e mt,
                                                    input logic [paddr_width_p-1:0] a);
    bp_bedrock_mem_header_s h;
    h          = '0;
    h.msg_type = mt;
    h.addr     = a;
    h.size     = e_bedrock_msg_size_8;
    return h;
  endfunction

  // Present a request in cycle 0; returns at cycle 1
  task automatic issue(input logic we, input logic [paddr_width_p-1:0] a, input logic [DW-1:0] d);
    req_v = 1'b1; req_we = we; req_addr = a; req_data = d;
    tick();
    req_v = 1'b0;
  endtask

  // Drive one response for a cycle; checks it is consumed
  task automatic respond(input string tag, input bp_bedrock_mem_header_s h, input logic [DW-1:0] d);
    rsp_v = 1'b1; rsp_hdr = h; rsp_data = d;
    #1;
    check({tag, "_yumi"}, 64'(rsp_yumi), 64'd1);
    tick();
    rsp_v = 1'b0;
  endtask

  // Consume a completion; the following cycle must be idle again
  task automatic consume(input string tag);
    resp_yumi = 1'b1;
    tick();
    resp_yumi = 1'b0;
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    check({tag, "_respv_low"}, 64'(resp_v), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; lce_id = 8'h5A;
    req_v = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0;
    resp_yumi = 1'b0; cmd_ready = 1'b1;
    rsp_v = 1'b0; rsp_hdr = '0; rsp_data = '0;
    repeat (3) tick();
    check("rst_resp_v", 64'(resp_v), 64'd0);
    check("rst_cmd_v", 64'(cmd_v), 64'd0);
    check("rst_stray", 64'(stray), 64'd0);
    check("rst_hdr", 64'(cmd_hdr_raw), 64'd0);
    reset_n = 1'b1;
    tick();
    check("idle_ready", 64'(req_ready), 64'd1);

    // Write 0x1000 / 0xDEADBEEF, immediate response
    issue(1'b1, 40'h1000, 64'hDEADBEEF);
    check("wr_cmd_v", 64'(cmd_v), 64'd1);
    check("wr_msg_type", 64'(ch.msg_type), 64'(e_bedrock_mem_uc_wr));
    check("wr_size", 64'(ch.size), 64'(e_bedrock_msg_size_8));
    check("wr_addr", 64'(ch.addr), 64'h1000);
    check("wr_lce_id", 64'(ch.payload.lce_id), 64'h5A);
    check("wr_cmd_data", cmd_data, 64'hDEADBEEF);
    check("wr_busy", 64'(req_ready), 64'd0);
    tick();
    check("wr_cmd_v_drop", 64'(cmd_v), 64'd0);
    respond("wr", mk_hdr(e_bedrock_mem_uc_wr, 40'h1000), 64'hFFFF);
    check("wr_resp_v_c3", 64'(resp_v), 64'd1);
    check("wr_err", 64'(resp_err), 64'd0);
    check("wr_data", resp_data, 64'd0);
    consume("wr");

    // Read 0x1008, response 10 cycles after e_wait entry, client stalls 5 cycles
    issue(1'b0, 40'h1008, 64'hABCD);
    check("rd_msg_type", 64'(ch.msg_type), 64'(e_bedrock_mem_uc_rd));
    check("rd_cmd_data", cmd_data, 64'd0);
    tick();
    repeat (10) tick();
    check("rd_no_resp_yet", 64'(resp_v), 64'd0);
    respond("rd", mk_hdr(e_bedrock_mem_uc_rd, 40'h1008), 64'h1234);
    for (int i = 0; i < 5; i++) begin
      check("rd_hold_v", 64'(resp_v), 64'd1);
      check("rd_hold_data", resp_data, 64'h1234);
      tick();
    end
    check("rd_err", 64'(resp_err), 64'd0);
    consume("rd");

    // Timeout: no response, completion at e_wait entry + 16
    issue(1'b0, 40'h1010, 64'd0);
    tick();
    repeat (TO - 1) tick();
    check("to_not_yet", 64'(resp_v), 64'd0);
    tick();
    check("to_resp_v", 64'(resp_v), 64'd1);
    check("to_err", 64'(resp_err), 64'd1);
    check("to_data", resp_data, 64'd0);
    consume("to");
    respond("late", mk_hdr(e_bedrock_mem_uc_rd, 40'h1010), 64'h77);
    check("late_stray", 64'(stray), 64'd1);

    // Response in the last timeout cycle wins
    issue(1'b0, 40'h1018, 64'd0);
    tick();
    repeat (TO - 1) tick();
    respond("edge", mk_hdr(e_bedrock_mem_uc_rd, 40'h1018), 64'h55);
    check("edge_err", 64'(resp_err), 64'd0);
    check("edge_data", resp_data, 64'h55);
    consume("edge");

    // Misaligned request: no command, error completion in cycle 1
    issue(1'b1, 40'h1003, 64'h99);
    check("mis_cmd_v", 64'(cmd_v), 64'd0);
    check("mis_resp_v", 64'(resp_v), 64'd1);
    check("mis_err", 64'(resp_err), 64'd1);
    check("mis_data", resp_data, 64'd0);
    consume("mis");

    // Mismatched address, then mismatched msg_type
    issue(1'b1, 40'h1000, 64'h1);
    tick();
    respond("bad_addr", mk_hdr(e_bedrock_mem_uc_wr, 40'h2000), 64'd0);
    check("bad_addr_err", 64'(resp_err), 64'd1);
    consume("bad_addr");
    issue(1'b0, 40'h1000, 64'h0);
    tick();
    respond("bad_type", mk_hdr(e_bedrock_mem_uc_wr, 40'h1000), 64'hCAFE);
    check("bad_type_err", 64'(resp_err), 64'd1);
    check("bad_type_data", resp_data, 64'd0);
    consume("bad_type");
    check("stray_unchanged", 64'(stray), 64'd1);

    // 300 stray responses in idle; count saturates
    rsp_v = 1'b1; rsp_hdr = mk_hdr(e_bedrock_mem_uc_rd, 40'h3000);
    repeat (100) tick();
    check("stray_101", 64'(stray), 64'd101);
    repeat (200) tick();
    rsp_v = 1'b0;
    check("stray_sat", 64'(stray), 64'd255);

    // Backpressure: held in e_send, no timeout
    cmd_ready = 1'b0;
    issue(1'b1, 40'h1020, 64'h4242);
    repeat (40) tick();
    check("bp_cmd_v", 64'(cmd_v), 64'd1);
    check("bp_addr", 64'(ch.addr), 64'h1020);
    check("bp_data", cmd_data, 64'h4242);
    check("bp_resp_v", 64'(resp_v), 64'd0);
    cmd_ready = 1'b1;
    tick();
    respond("bp", mk_hdr(e_bedrock_mem_uc_wr, 40'h1020), 64'd0);
    check("bp_err", 64'(resp_err), 64'd0);
    consume("bp");

    // Async reset while in e_wait
    issue(1'b0, 40'h1028, 64'd0);
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("ar_cmd_v", 64'(cmd_v), 64'd0);
    check("ar_hdr", 64'(cmd_hdr_raw), 64'd0);
    check("ar_stray", 64'(stray), 64'd0);
    check("ar_resp_v", 64'(resp_v), 64'd0);
    check("ar_idle", 64'(req_ready), 64'd1);
    tick();
    reset_n = 1'b1;
    tick();
    respond("ar_late", mk_hdr(e_bedrock_mem_uc_rd, 40'h1028), 64'h1);
    check("ar_late_stray", 64'(stray), 64'd1);
    issue(1'b0, 40'h1030, 64'd0);
    tick();
    respond("ar_new", mk_hdr(e_bedrock_mem_uc_rd, 40'h1030), 64'h0BAD_F00D);
    check("ar_new_err", 64'(resp_err), 64'd0);
    check("ar_new_data", resp_data, 64'h0BAD_F00D);
    consume("ar_new");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
